gpio_port_reg: RTL and testbench
================================

GPIO_PORT_REG -- requirements
Module: gpio_port_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, range 1..32: number of GPIO bits.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, range 2..4: input synchronizer depth.
REQ-003 The module SHALL have port sysClk, input, 1 bit: the single clock for all logic.
REQ-004 The module SHALL have port sysReset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port sysCsrStrobe, input, 1 bit: one-cycle CSR write strobe.
REQ-006 The module SHALL have port sysCsrAddr, input, 3 bits: register select for write and read.
REQ-007 The module SHALL have port sysGpioOut, input, 32 bits: CSR write data.
REQ-008 The module SHALL have port sysCsr, output, 32 bits: read data for the register selected by sysCsrAddr.
REQ-009 The module SHALL have port gpioIn, input, WIDTH bits: asynchronous external inputs.
REQ-010 The module SHALL have port gpioOut, output, WIDTH bits: registered output data.
REQ-011 The module SHALL have port gpioOe, output, WIDTH bits: registered output enable, 1 = drive.
REQ-012 The module SHALL have port irq, output, 1 bit: registered OR of unmasked sticky edge status.

Function
REQ-013 The address map SHALL be: 0 OUT, 1 SET, 2 CLR, 3 TGL, 4 DIR, 5 IN, 6 EDGE_EN, 7 STATUS.
REQ-014 On a write to OUT, the OUT register SHALL load sysGpioOut[WIDTH-1:0] on the strobe edge.
REQ-015 On a write to SET, CLR or TGL, each OUT bit with a 1 in the write data SHALL be set, cleared or inverted respectively; all other bits are unchanged.
REQ-016 On a write to DIR or EDGE_EN, the addressed register SHALL load the write data.
REQ-017 Writes to IN SHALL be ignored.
REQ-018 On a write to STATUS, each bit with a 1 in the write data SHALL be cleared (write-1-clear).
REQ-019 sysCsr SHALL be combinational from sysCsrAddr, with these contents:
  - addresses 0-3: OUT;
  - 4: DIR;
  - 5: synchronized input;
  - 6: EDGE_EN;
  - 7: STATUS;
  - bits 31:WIDTH: read as 0.
REQ-020 gpioOut SHALL equal OUT and gpioOe SHALL equal DIR, with a visible latency of one clock after the strobe edge.
REQ-021 gpioIn SHALL pass through a SYNC_STAGES flip-flop chain, then through one further "previous" register.
REQ-022 Rising-edge detect SHALL be: synced & ~previous & EDGE_EN & armed.
REQ-023 A detected edge SHALL set its STATUS bit on the next clock edge. If gpioIn rises before clock edge k, STATUS is set at edge k+SYNC_STAGES, and only a rise (not a level) sets it.
REQ-024 If an edge-set and a W1C clear hit the same STATUS bit in the same cycle, set SHALL win.
REQ-025 irq SHALL be registered as |STATUS, so it asserts one clock after STATUS becomes nonzero and deasserts one clock after STATUS becomes zero.
REQ-026 Clearing an EDGE_EN bit SHALL block new sets for that bit but SHALL NOT clear an existing STATUS bit.
REQ-027 An arming counter SHALL count from 0 to SYNC_STAGES+1 after reset deassertion and then hold. armed = (counter == SYNC_STAGES+1), which suppresses false edges from inputs that are already high at reset.
REQ-028 Write data bits above WIDTH-1 SHALL be ignored.
REQ-029 A strobe SHALL act on exactly one register per cycle, with no pipelining of writes.

Reset
REQ-030 While sysReset_n = 0, the following SHALL be 0 asynchronously:
  - OUT, DIR, EDGE_EN, STATUS;
  - the synchronizer and previous registers;
  - the arming counter;
  - irq, gpioOut, gpioOe.
REQ-031 Reset asserted mid-operation SHALL discard pending edges and SHALL restart arming.
REQ-032 Release of sysReset_n SHALL be synchronous to sysClk in the integrating design; the block itself adds no reset synchronizer.

Verification
REQ-033 WIDTH=8. Write OUT=0xA5, then SET=0x0F, CLR=0x81, TGL=0xFF. Required: gpioOut reads 0xA5, 0xAF, 0x2E, 0xD1 in sequence, each one clock after its strobe, and sysCsr at addr 0 matches.
REQ-034 Write DIR=0x3C. Required: gpioOe = 0x3C; reads at addr 4 = 0x0000003C; write 0xFFFFFFFF to IN leaves addr 5 reads unchanged.
REQ-035 SYNC_STAGES=2, EDGE_EN=0x01, gpioIn[0] rises before edge k. Required: STATUS=0x01 at edge k+2, irq=1 at edge k+3; holding gpioIn high causes no further change.
REQ-036 STATUS=0x01. Write STATUS=0x01 in the same cycle a new bit-0 edge is detected. Required: STATUS stays 0x01; a later W1C with no edge clears it to 0, and irq drops one clock after that.
REQ-037 Hold gpioIn=0xFF with EDGE_EN=0xFF through reset release. Required: STATUS remains 0x00 and irq stays 0.
REQ-038 Assert sysReset_n=0 mid-run with OUT=0x55, STATUS=0x02. Required: gpioOut, gpioOe, STATUS and irq all read 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/gpio_port_reg.sv
// GPIO port register block: CSR-controlled output/direction registers plus a
// synchronized input path with armed rising-edge detect, sticky status and irq.
module gpio_port_reg #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             sysClk,
    input  logic             sysReset_n,
    input  logic             sysCsrStrobe,
    input  logic [2:0]       sysCsrAddr,
    input  logic [31:0]      sysGpioOut,
    output logic [31:0]      sysCsr,
    input  logic [WIDTH-1:0] gpioIn,
    output logic [WIDTH-1:0] gpioOut,
    output logic [WIDTH-1:0] gpioOe,
    output logic             irq
);

    typedef enum logic [2:0] {
        ADDR_OUT     = 3'd0,
        ADDR_SET     = 3'd1,
        ADDR_CLR     = 3'd2,
        ADDR_TGL     = 3'd3,
        ADDR_DIR     = 3'd4,
        ADDR_IN      = 3'd5,
        ADDR_EDGE_EN = 3'd6,
        ADDR_STATUS  = 3'd7
    } csr_addr_t;

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    csr_addr_t        addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
    logic [2:0]       arm_cnt;
    logic             armed;
    logic             irq_q;

    assign addr   = csr_addr_t'(sysCsrAddr);
    assign wdata  = sysGpioOut[WIDTH-1:0];
    assign synced = sync_q[SYNC_STAGES-1];
    assign armed  = (arm_cnt == ARM_MAX);
    assign rise   = synced & ~prev_q & en_q & {WIDTH{armed}};
    assign w1c    = (sysCsrStrobe && addr == ADDR_STATUS) ? wdata : '0;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= gpioIn;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= synced;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            out_q <= '0;
            dir_q <= '0;
            en_q  <= '0;
        end else if (sysCsrStrobe) begin
            case (addr)
                ADDR_OUT:     out_q <= wdata;
                ADDR_SET:     out_q <= out_q | wdata;
                ADDR_CLR:     out_q <= out_q & ~wdata;
                ADDR_TGL:     out_q <= out_q ^ wdata;
                ADDR_DIR:     dir_q <= wdata;
                ADDR_EDGE_EN: en_q  <= wdata;
                default:      ;
            endcase
        end
    end

    // Edge set is OR'd in after the W1C mask so a coincident set wins.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~w1c) | rise;
            irq_q    <= |status_q;
        end
    end

    always_comb begin
        sysCsr = '0;
        case (addr)
            ADDR_OUT, ADDR_SET, ADDR_CLR, ADDR_TGL: sysCsr[WIDTH-1:0] = out_q;
            ADDR_DIR:                               sysCsr[WIDTH-1:0] = dir_q;
            ADDR_IN:                                sysCsr[WIDTH-1:0] = synced;
            ADDR_EDGE_EN:                           sysCsr[WIDTH-1:0] = en_q;
            ADDR_STATUS:                            sysCsr[WIDTH-1:0] = status_q;
            default:                                sysCsr = '0;
        endcase
    end

    assign gpioOut = out_q;
    assign gpioOe  = dir_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_port_reg.sv
// Directed bench for gpio_port_reg at WIDTH=8, SYNC_STAGES=2 with
// hand-computed expectations checked by immediate assertions.
module tb_gpio_port_reg;

    logic        sysClk = 1'b0;
    logic        sysReset_n;
    logic        sysCsrStrobe;
    logic [2:0]  sysCsrAddr;
    logic [31:0] sysGpioOut;
    logic [31:0] sysCsr;
    logic [7:0]  gpioIn;
    logic [7:0]  gpioOut;
    logic [7:0]  gpioOe;
    logic        irq;

    int n_checks = 0;
    int n_fails  = 0;

    gpio_port_reg #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .sysClk       (sysClk),
        .sysReset_n   (sysReset_n),
        .sysCsrStrobe (sysCsrStrobe),
        .sysCsrAddr   (sysCsrAddr),
        .sysGpioOut   (sysGpioOut),
        .sysCsr       (sysCsr),
        .gpioIn       (gpioIn),
        .gpioOut      (gpioOut),
        .gpioOe       (gpioOe),
        .irq          (irq)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge sysClk);
        sysCsrStrobe = 1'b1;
        sysCsrAddr   = a;
        sysGpioOut   = d;
        @(posedge sysClk);
        #1;
        sysCsrStrobe = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sysCsrAddr = a;
        #1;
        check(tag, sysCsr, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sysClk);
        #1;
    endtask

    initial begin
        sysReset_n   = 1'b1;
        sysCsrStrobe = 1'b0;
        sysCsrAddr   = 3'd0;
        sysGpioOut   = '0;
        gpioIn       = '0;
        #1 sysReset_n = 1'b0;
        #2;
        check("rst_gpioOut", {24'd0, gpioOut}, 32'h0);
        check("rst_gpioOe",  {24'd0, gpioOe},  32'h0);
        check("rst_irq",     {31'd0, irq},     32'h0);
        rd("rst_status", 3'd7, 32'h0);
        cycles(2);
        @(negedge sysClk) sysReset_n = 1'b1;

        // Output register operations; upper write bits must be dropped
        wr(3'd0, 32'h1234_56A5);
        check("out_wr", {24'd0, gpioOut}, 32'hA5);
        rd("out_rd", 3'd0, 32'h0000_00A5);
        wr(3'd1, 32'h0000_000F);
        check("set_wr", {24'd0, gpioOut}, 32'hAF);
        rd("set_rd", 3'd1, 32'h0000_00AF);
        wr(3'd2, 32'h0000_0081);
        check("clr_wr", {24'd0, gpioOut}, 32'h2E);
        rd("clr_rd", 3'd0, 32'h0000_002E);
        wr(3'd3, 32'hFFFF_FFFF);
        check("tgl_wr", {24'd0, gpioOut}, 32'hD1);
        rd("tgl_rd", 3'd3, 32'h0000_00D1);

        // Direction and the read-only input register
        wr(3'd4, 32'h0000_003C);
        check("dir_oe", {24'd0, gpioOe}, 32'h3C);
        rd("dir_rd", 3'd4, 32'h0000_003C);
        gpioIn = 8'h5A;
        cycles(3);
        rd("in_rd", 3'd5, 32'h0000_005A);
        wr(3'd5, 32'hFFFF_FFFF);
        rd("in_ro", 3'd5, 32'h0000_005A);
        rd("in_wr_out", 3'd0, 32'h0000_00D1);
        rd("in_wr_dir", 3'd4, 32'h0000_003C);
        rd("no_edge_en", 3'd7, 32'h0);
        gpioIn = 8'h00;
        cycles(3);

        // Rising edge on bit 0 with latency SYNC_STAGES to STATUS, +1 to irq
        wr(3'd6, 32'h0000_0001);
        rd("en_rd", 3'd6, 32'h0000_0001);
        sysCsrAddr = 3'd7;
        @(negedge sysClk) gpioIn = 8'h01;
        @(posedge sysClk);
        cycles(1);
        check("edge_k1", sysCsr, 32'h0);
        cycles(1);
        check("edge_k2", sysCsr, 32'h1);
        check("irq_k2", {31'd0, irq}, 32'h0);
        cycles(1);
        check("irq_k3", {31'd0, irq}, 32'h1);
        gpioIn = 8'h03;
        cycles(4);
        check("hold_level", sysCsr, 32'h1);

        // Coincident W1C and edge on bit 0: set wins
        gpioIn = 8'h00;
        cycles(3);
        @(negedge sysClk) gpioIn = 8'h01;
        @(negedge sysClk);
        wr(3'd7, 32'h0000_0001);
        rd("set_wins", 3'd7, 32'h1);
        check("set_wins_irq", {31'd0, irq}, 32'h1);
        gpioIn = 8'h00;
        cycles(1);
        wr(3'd7, 32'h0000_0001);
        rd("w1c_clear", 3'd7, 32'h0);
        check("irq_hold", {31'd0, irq}, 32'h1);
        cycles(1);
        check("irq_drop", {31'd0, irq}, 32'h0);

        // Disabling EDGE_EN keeps existing status and blocks new sets
        wr(3'd6, 32'h0000_0003);
        gpioIn = 8'h02;
        cycles(3);
        rd("bit1_set", 3'd7, 32'h2);
        wr(3'd6, 32'h0000_0001);
        rd("en_off_keep", 3'd7, 32'h2);
        gpioIn = 8'h00;
        cycles(3);
        gpioIn = 8'h02;
        cycles(4);
        rd("en_off_block", 3'd7, 32'h2);

        // Asynchronous reset mid-cycle
        wr(3'd0, 32'h0000_0055);
        check("pre_rst_out", {24'd0, gpioOut}, 32'h55);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        sysCsrAddr = 3'd7;
        @(posedge sysClk);
        #2 sysReset_n = 1'b0;
        #1;
        check("arst_out", {24'd0, gpioOut}, 32'h0);
        check("arst_oe",  {24'd0, gpioOe},  32'h0);
        check("arst_irq", {31'd0, irq},     32'h0);
        check("arst_status", sysCsr, 32'h0);

        // Inputs already high through reset release must not set status
        gpioIn = 8'hFF;
        @(negedge sysClk);
        sysCsrStrobe = 1'b1;
        sysCsrAddr   = 3'd6;
        sysGpioOut   = 32'h0000_00FF;
        @(negedge sysClk) sysReset_n = 1'b1;
        @(posedge sysClk);
        #1 sysCsrStrobe = 1'b0;
        rd("arm_en", 3'd6, 32'h0000_00FF);
        sysCsrAddr = 3'd7;
        cycles(6);
        check("arm_status", sysCsr, 32'h0);
        check("arm_irq", {31'd0, irq}, 32'h0);
        gpioIn = 8'hFB;
        cycles(3);
        gpioIn = 8'hFF;
        cycles(3);
        check("armed_edge", sysCsr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
